// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU interface: decodes one request, drives registered ALU operands,
// samples the ALU result after ALU_LAT cycles and returns it over a response handshake.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7_5,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_imm,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_taken,
  output logic        rsp_illegal
);
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_IDLE = 4'b1111;
  localparam logic [3:0] CNT_INIT  = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r;
  logic [31:0] alu_in_1_r, alu_in_2_r, rsp_result_r;
  logic [3:0]  alu_ctrl_r;
  logic        rsp_taken_r, rsp_illegal_r;
  logic        is_slt_r, is_br_r, is_bne_r, rs1_sign_r, op2_sign_r;
  logic        dec_legal_s, dec_slt_s, dec_br_s, dec_bne_s;
  logic [3:0]  dec_ctrl_s;
  logic [31:0] dec_op2_s;
  logic        req_ready_s, rsp_valid_s, accept_s, slt_lt_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = accept_s ? (dec_legal_s ? ST_EXEC : ST_RESP) : ST_IDLE;
      ST_EXEC: state_nxt_s = (cnt_r == 4'd0) ? ST_RESP : ST_EXEC;
      ST_RESP: state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    req_ready_s = (state_r == ST_IDLE) && !rst;
    rsp_valid_s = (state_r == ST_RESP);
    accept_s    = req_valid && req_ready_s;
  end

  // Opcode/funct decode of the pending request
  always_comb begin
    dec_legal_s = 1'b0;
    dec_ctrl_s  = CTRL_IDLE;
    dec_op2_s   = req_rs2;
    dec_slt_s   = 1'b0;
    dec_br_s    = 1'b0;
    dec_bne_s   = 1'b0;
    case (req_opcode)
      7'b0110011, 7'b0010011: begin
        dec_op2_s = (req_opcode == 7'b0010011) ? req_imm : req_rs2;
        case (req_funct3)
          3'b000: begin
            dec_legal_s = 1'b1;
            dec_ctrl_s  = (req_opcode == 7'b0110011 && req_funct7_5) ? CTRL_SUB : CTRL_ADD;
          end
          3'b111: begin dec_legal_s = 1'b1; dec_ctrl_s = CTRL_AND; end
          3'b110: begin dec_legal_s = 1'b1; dec_ctrl_s = CTRL_OR;  end
          3'b010: begin dec_legal_s = 1'b1; dec_ctrl_s = CTRL_SUB; dec_slt_s = 1'b1; end
          default: dec_legal_s = 1'b0;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        dec_legal_s = 1'b1;
        dec_ctrl_s  = CTRL_ADD;
        dec_op2_s   = req_imm;
      end
      7'b1100011: begin
        dec_ctrl_s  = CTRL_SUB;
        dec_br_s    = 1'b1;
        dec_bne_s   = (req_funct3 == 3'b001);
        dec_legal_s = (req_funct3 == 3'b000) || (req_funct3 == 3'b001);
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // Signed less-than: differing signs decide directly, otherwise the difference sign is exact
  assign slt_lt_s = (rs1_sign_r ^ op2_sign_r) ? rs1_sign_r : alu_out[31];

  // Operand, control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in_1_r    <= 32'd0;
      alu_in_2_r    <= 32'd0;
      alu_ctrl_r    <= CTRL_IDLE;
      cnt_r         <= 4'd0;
      rsp_result_r  <= 32'd0;
      rsp_taken_r   <= 1'b0;
      rsp_illegal_r <= 1'b0;
      is_slt_r      <= 1'b0;
      is_br_r       <= 1'b0;
      is_bne_r      <= 1'b0;
      rs1_sign_r    <= 1'b0;
      op2_sign_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && dec_legal_s) begin
            alu_in_1_r <= req_rs1;
            alu_in_2_r <= dec_op2_s;
            alu_ctrl_r <= dec_ctrl_s;
            cnt_r      <= CNT_INIT;
            is_slt_r   <= dec_slt_s;
            is_br_r    <= dec_br_s;
            is_bne_r   <= dec_bne_s;
            rs1_sign_r <= req_rs1[31];
            op2_sign_r <= dec_op2_s[31];
          end else if (accept_s) begin
            rsp_result_r  <= 32'd0;
            rsp_taken_r   <= 1'b0;
            rsp_illegal_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_EXEC: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            rsp_result_r  <= is_slt_r ? {31'd0, slt_lt_s} : alu_out;
            rsp_taken_r   <= is_br_r & (zero ^ is_bne_r);
            rsp_illegal_r <= 1'b0;
            alu_ctrl_r    <= CTRL_IDLE;
            alu_in_1_r    <= 32'd0;
            alu_in_2_r    <= 32'd0;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign req_ready   = req_ready_s;
  assign rsp_valid   = rsp_valid_s;
  assign alu_in_1    = alu_in_1_r;
  assign alu_in_2    = alu_in_2_r;
  assign alu_ctrl    = alu_ctrl_r;
  assign rsp_result  = rsp_result_r;
  assign rsp_taken   = rsp_taken_r;
  assign rsp_illegal = rsp_illegal_r;
endmodule
